// File: rtl/tree_walk_engine.sv
// Decision-tree walker: nodes live in a single-port synchronous RAM. Each walk
// fetches nodes from the root and compares one feature per node until it reaches a leaf.
module tree_walk_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int FEAT_W     = 16,
  parameter int NUM_FEAT   = 8,
  parameter int FIDX_W     = 4,
  parameter int CLASS_W    = 4,
  parameter int MAX_DEPTH  = 16,
  localparam int NODE_W    = 1 + FIDX_W + FEAT_W + 2*ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prog_we,
  input  logic [ADDR_WIDTH-1:0]      prog_addr,
  input  logic [NODE_W-1:0]          prog_data,
  output logic                       prog_drop,
  input  logic                       start,
  input  logic [ADDR_WIDTH-1:0]      root_addr,
  input  logic [NUM_FEAT*FEAT_W-1:0] feat_vec,
  output logic                       ready,
  output logic                       done,
  output logic [CLASS_W-1:0]         class_out,
  output logic [4:0]                 depth_out,
  output logic                       err
);

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

  localparam logic [4:0] MAX_D = 5'(MAX_DEPTH);

  logic [NODE_W-1:0]          mem [2**ADDR_WIDTH];
  logic [NODE_W-1:0]          rd_q;
  logic [NUM_FEAT*FEAT_W-1:0] feat_q, feat_d;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      cur_q, cur_d;
  logic [4:0]                 depth_q, depth_d;
  logic [CLASS_W-1:0]         cls_q, cls_d;
  logic                       err_stg_q, err_stg_d;
  logic [CLASS_W-1:0]         class_q, class_d;
  logic [4:0]                 depth_out_q, depth_out_d;
  logic                       err_q, err_d;
  logic                       done_q, done_d;
  logic                       drop_q, drop_d;

  logic                       wr_en;
  logic [ADDR_WIDTH-1:0]      ram_addr;

  logic                       is_leaf;
  logic [FIDX_W-1:0]          fidx;
  logic [FEAT_W-1:0]          thresh;
  logic [ADDR_WIDTH-1:0]      left_a, right_a;
  logic [FEAT_W-1:0]          feat_sel;
  logic                       bad_idx;

  assign is_leaf = rd_q[NODE_W-1];
  assign fidx    = rd_q[NODE_W-2 -: FIDX_W];
  assign thresh  = rd_q[2*ADDR_WIDTH +: FEAT_W];
  assign left_a  = rd_q[ADDR_WIDTH +: ADDR_WIDTH];
  assign right_a = rd_q[0 +: ADDR_WIDTH];
  assign bad_idx = (int'(fidx) >= NUM_FEAT);

  // Writes are only legal while idle, so the one RAM port is shared by address muxing.
  assign wr_en    = prog_we && (state_q == IDLE);
  assign ram_addr = (state_q == IDLE) ? prog_addr : cur_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[ram_addr] <= prog_data;
    if (state_q == FETCH) rd_q <= mem[ram_addr];
    feat_q <= feat_d;
  end

  always_comb begin
    feat_sel = '0;
    for (int k = 0; k < NUM_FEAT; k++) begin
      if (fidx == FIDX_W'(k)) feat_sel = feat_q[k*FEAT_W +: FEAT_W];
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    depth_d     = depth_q;
    feat_d      = feat_q;
    cls_d       = cls_q;
    err_stg_d   = err_stg_q;
    class_d     = class_q;
    depth_out_d = depth_out_q;
    err_d       = err_q;
    done_d      = 1'b0;
    drop_d      = prog_we && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          feat_d  = feat_vec;
          cur_d   = root_addr;
          depth_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        depth_d = depth_q + 5'd1;
        state_d = EVAL;
      end
      EVAL: begin
        if (is_leaf) begin
          cls_d     = thresh[CLASS_W-1:0];
          err_stg_d = 1'b0;
          state_d   = DONE;
        end else if (bad_idx || depth_q == MAX_D) begin
          cls_d     = '0;
          err_stg_d = 1'b1;
          state_d   = DONE;
        end else begin
          cur_d   = (feat_sel <= thresh) ? left_a : right_a;
          state_d = FETCH;
        end
      end
      DONE: begin
        // Results are published together with the done pulse so they never change mid-walk.
        done_d      = 1'b1;
        class_d     = cls_q;
        err_d       = err_stg_q;
        depth_out_d = depth_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      depth_q     <= '0;
      cls_q       <= '0;
      err_stg_q   <= 1'b0;
      class_q     <= '0;
      depth_out_q <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      depth_q     <= depth_d;
      cls_q       <= cls_d;
      err_stg_q   <= err_stg_d;
      class_q     <= class_d;
      depth_out_q <= depth_out_d;
      err_q       <= err_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign done      = done_q;
  assign class_out = class_q;
  assign depth_out = depth_out_q;
  assign err       = err_q;
  assign prog_drop = drop_q;

endmodule

// File: tb/tb_tree_walk_engine.sv
// Directed bench for tree_walk_engine: hand-built trees with known class,
// depth, error and latency results, plus collision and reset scenarios.
module tb_tree_walk_engine;

  localparam int AW  = 10;
  localparam int FW  = 16;
  localparam int NF  = 8;
  localparam int FIW = 4;
  localparam int CW  = 4;
  localparam int MD  = 16;
  localparam int NW  = 1 + FIW + FW + 2*AW;

  logic              clk = 1'b0;
  logic              rst;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [NW-1:0]     prog_data;
  logic              prog_drop;
  logic              start;
  logic [AW-1:0]     root_addr;
  logic [NF*FW-1:0]  feat_vec;
  logic              ready;
  logic              done;
  logic [CW-1:0]     class_out;
  logic [4:0]        depth_out;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;
  int lat;
  bit seen_done;

  tree_walk_engine #(
    .ADDR_WIDTH(AW), .FEAT_W(FW), .NUM_FEAT(NF),
    .FIDX_W(FIW), .CLASS_W(CW), .MAX_DEPTH(MD)
  ) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_drop(prog_drop),
    .start(start), .root_addr(root_addr), .feat_vec(feat_vec),
    .ready(ready), .done(done), .class_out(class_out), .depth_out(depth_out), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NW-1:0] node(input logic leaf, input logic [FIW-1:0] fi,
                                         input logic [FW-1:0] th, input logic [AW-1:0] l,
                                         input logic [AW-1:0] r);
    return {leaf, fi, th, l, r};
  endfunction

  // Called at a negedge; the write lands on the following posedge.
  task automatic prog(input logic [AW-1:0] a, input logic [NW-1:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Called at a negedge. lat = posedges from the start edge to the edge that raised done.
  task automatic walk(input logic [AW-1:0] root, input logic [FW-1:0] f2, input bit inj,
                      output int lat_o);
    logic [NF*FW-1:0] fv;
    fv = {NF{16'hA5A5}};
    fv[2*FW +: FW] = f2;
    start = 1'b1; root_addr = root; feat_vec = fv;
    lat_o = 999;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
      if (i == 1) feat_vec = ~fv;
      if (done) begin
        lat_o = i - 1;
        break;
      end
      if (inj && i == 2) begin
        start = 1'b1; root_addr = root + AW'(1); feat_vec = '0;
        prog_we = 1'b1; prog_addr = AW'(1); prog_data = node(1'b1, '0, 16'h000F, '0, '0);
      end
      if (inj && i == 3) check("prog_drop_pulse", prog_drop, 1);
    end
  endtask

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; root_addr = '0; feat_vec = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_class", class_out, 0);
    check("rst_depth", depth_out, 0);
    check("rst_err", err, 0);
    check("rst_drop", prog_drop, 0);
    rst = 1'b0;

    // Leaf root
    prog(AW'(0), node(1'b1, '0, 16'h0005, '0, '0));
    check("idle_write_no_drop", prog_drop, 0);
    walk(AW'(0), 16'h0000, 1'b0, lat);
    check("leaf_lat", lat, 3);
    check("leaf_class", class_out, 5);
    check("leaf_depth", depth_out, 1);
    check("leaf_err", err, 0);
    check("leaf_ready_at_done", ready, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // Two-level tree
    prog(AW'(0), node(1'b0, 4'd2, 16'h0100, AW'(1), AW'(2)));
    prog(AW'(1), node(1'b1, '0, 16'h0003, '0, '0));
    prog(AW'(2), node(1'b1, '0, 16'h0007, '0, '0));
    walk(AW'(0), 16'h0100, 1'b0, lat);
    check("eq_left_lat", lat, 5);
    check("eq_left_class", class_out, 3);
    check("eq_left_depth", depth_out, 2);
    check("eq_left_err", err, 0);
    walk(AW'(0), 16'h0101, 1'b1, lat);
    check("gt_right_class", class_out, 7);
    check("gt_right_depth", depth_out, 2);
    repeat (4) @(negedge clk);
    check("class_hold", class_out, 7);
    check("depth_hold", depth_out, 2);
    walk(AW'(0), 16'h0100, 1'b0, lat);
    check("dropped_write_class", class_out, 3);
    walk(AW'(0), 16'h8000, 1'b0, lat);
    check("unsigned_cmp_class", class_out, 7);
    walk(AW'(0), 16'h0000, 1'b0, lat);
    check("zero_feat_class", class_out, 3);
    walk(AW'(2), 16'h0000, 1'b0, lat);
    check("root2_class", class_out, 7);
    check("root2_depth", depth_out, 1);

    // Reset during EVAL
    start = 1'b1; root_addr = AW'(0); feat_vec = {NF{16'h0100}};
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_class", class_out, 0);
    check("midrst_depth", depth_out, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", seen_done, 0);
    walk(AW'(0), 16'h0101, 1'b0, lat);
    check("post_rst_lat", lat, 5);
    check("post_rst_class", class_out, 7);

    // Bad feature index
    prog(AW'(0), node(1'b0, 4'd9, 16'h0100, AW'(1), AW'(2)));
    walk(AW'(0), 16'h0000, 1'b0, lat);
    check("badidx_err", err, 1);
    check("badidx_class", class_out, 0);
    check("badidx_depth", depth_out, 1);
    check("badidx_lat", lat, 3);

    // Self-loop hits the depth limit
    prog(AW'(0), node(1'b0, 4'd0, 16'h0000, AW'(0), AW'(0)));
    walk(AW'(0), 16'h0000, 1'b0, lat);
    check("loop_err", err, 1);
    check("loop_depth", depth_out, 16);
    check("loop_lat", lat, 33);
    check("loop_class", class_out, 0);

    // Write and start on the same edge
    prog(AW'(3), node(1'b1, '0, 16'h0002, '0, '0));
    prog_we = 1'b1; prog_addr = AW'(3); prog_data = node(1'b1, '0, 16'h0009, '0, '0);
    walk(AW'(3), 16'h0000, 1'b0, lat);
    check("wr_start_class", class_out, 9);
    check("wr_start_err", err, 0);
    check("wr_start_lat", lat, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tree_walk_engine.md
TREE_WALK_ENGINE -- requirements
Module: tree_walk_engine

Interface
REQ-001 Parameters (name, default, meaning); node word NODE_W = 1+FIDX_W+FEAT_W+2*ADDR_W:
- ADDR_WIDTH, 10, node-memory address width; depth = 2**ADDR_WIDTH.
- FEAT_W, 16, feature and threshold width, unsigned.
- NUM_FEAT, 8, features per vector.
- FIDX_W, 4, feature-index field width; NUM_FEAT <= 2**FIDX_W.
- CLASS_W, 4, class width; CLASS_W <= FEAT_W.
- MAX_DEPTH, 16, maximum nodes visited per walk.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, asynchronous, active-high reset.
- prog_we, in, 1, node-memory write strobe.
- prog_addr, in, ADDR_WIDTH, write address.
- prog_data, in, NODE_W, node word to write.
- prog_drop, out, 1, one-cycle pulse when a write is discarded.
- start, in, 1, request a walk.
- root_addr, in, ADDR_WIDTH, root node of the tree to walk.
- feat_vec, in, NUM_FEAT*FEAT_W, features; feature k is bits [k*FEAT_W +: FEAT_W].
- ready, out, 1, high when idle and a start will be accepted.
- done, out, 1, one-cycle pulse when class_out, depth_out and err are valid.
- class_out, out, CLASS_W, class from the leaf reached.
- depth_out, out, 5, number of nodes visited, leaf included.
- err, out, 1, walk aborted.
REQ-003 Node word fields, MSB first: is_leaf[1], fidx[FIDX_W], thresh[FEAT_W], left[ADDR_W], right[ADDR_W]. For a leaf, the class is thresh[CLASS_W-1:0] and the other fields are don't-care.

Function
REQ-004 Node storage is a single-port synchronous RAM of 2**ADDR_WIDTH x NODE_W with 1-cycle registered read. It has no initial contents and is not cleared by rst.
REQ-005 States are IDLE, FETCH, EVAL and DONE. ready=1 only in IDLE.
REQ-006 IDLE: start=1 captures feat_vec into an internal register, loads cur=root_addr and depth=0, then goes to FETCH. feat_vec changes after acceptance have no effect on the walk.
REQ-007 FETCH: present cur to the RAM, depth<=depth+1, go to EVAL.
REQ-008 EVAL: RAM output is valid.
- is_leaf=1: class_out<=thresh[CLASS_W-1:0], err<=0, go to DONE.
- Otherwise, if fidx>=NUM_FEAT: err<=1, class_out<=0, go to DONE.
- Otherwise, if depth==MAX_DEPTH: err<=1, class_out<=0, go to DONE.
- Otherwise: cur<=(feature[fidx] <= thresh) ? left : right, then go to FETCH.
REQ-009 DONE: done=1 for exactly this one cycle, depth_out<=depth, then go to IDLE.
REQ-010 class_out, depth_out and err hold their values until the next DONE.
REQ-011 Latency: with start sampled at edge t and N nodes visited, done is high in the cycle following edge t+2N+1. Minimum latency is 3 cycles (root is a leaf). Back-to-back walks require start in the cycle after done.
REQ-012 start while ready=0 is ignored: no queuing, no effect on the current walk.
REQ-013 prog_we while in IDLE writes prog_data to prog_addr at that edge.
REQ-014 prog_we while not in IDLE discards the write and pulses prog_drop the next cycle.
REQ-015 prog_we and start together in IDLE: the write commits and the walk starts. A FETCH of that same address in the following cycle returns the new data.
REQ-016 Threshold comparison is unsigned FEAT_W-bit, and equality takes the left branch.
REQ-017 cur is ADDR_WIDTH wide, so any child address is legal and wraps naturally; there is no out-of-range check.

Reset
REQ-018 Asserting rst, at any time and including mid-walk, forces IDLE and clears cur, depth, class_out, depth_out, err, done and prog_drop to 0. ready=1 during and after reset.
REQ-019 A walk interrupted by reset produces no done. RAM contents are preserved.
REQ-020 Reset deassertion is synchronised externally. The first start is accepted on the first edge with rst=0.

Verification
REQ-021 Leaf root: program node 0x000 as a leaf with class 5; start with root=0. Required: done 3 cycles later, class_out=5, depth_out=1, err=0.
REQ-022 Two-level tree:
- Setup: node 0 is internal with fidx=2, thresh=0x0100, left=1, right=2; node 1 is a leaf with class 3; node 2 is a leaf with class 7.
- feature2=0x0100: class_out=3, depth_out=2, latency 5.
- feature2=0x0101: class_out=7.
REQ-023 Bad index: set node 0 fidx=9 with NUM_FEAT=8. Required: err=1, class_out=0, depth_out=1.
REQ-024 Self-loop: set node 0 as internal with left=right=0. Required: err=1, depth_out=16, done exactly 33 cycles after start.
REQ-025 Collisions:
- prog_we during a walk: prog_drop=1 and RAM unchanged.
- start during a walk: ignored, result unchanged.
REQ-026 Reset mid-walk: assert rst during EVAL. Required: no done, ready=1, all outputs 0; a subsequent walk returns the correct class.
